mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the word-wide data memory interface (address, write data, write/read strobes, read data).
- Accepts MIPS load/store requests from the pipeline: byte, halfword and word, signed or unsigned.
- Drives word-aligned memory accesses, performs read-modify-write for sub-word stores, and returns extended load data with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, width of request and memory address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for sub-word stores.
- resp_valid  out  1  one-cycle pulse marking request completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; flags a misaligned address or reserved size.
- mem_addr  out  ADDR_W  word address to memory; bits [1:0] always 0.
- mem_wdata  out  32  write data to memory.
- mem_write  out  1  memory write strobe; memory writes on the clk edge.
- mem_read  out  1  memory read strobe.
- mem_rdata  in  32  memory read data, combinationally valid in the same cycle as mem_read.

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE.
  - All outputs 0 except req_ready = 1.
  - Request registers are cleared.
  - A reset mid-operation aborts the access with no response. A write strobe is never re-issued after reset.
- Byte order is little-endian: offset 0 maps to bits [7:0], offset 3 to bits [31:24].
- States: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - req_ready = 1. On req_valid, capture all request fields.
  - Error case: size 11, halfword with addr[0] = 1, or word with addr[1:0] != 0. Go to RESP with err = 1 and issue no memory strobe.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Load: mem_read = 1. Capture mem_rdata, select the byte/halfword by offset, extend per req_unsigned. Next state RESP.
  - Word store: mem_write = 1, mem_wdata = wdata. Next state RESP.
  - Sub-word store: mem_read = 1, capture mem_rdata into a merge register. Next state MERGE_WR.
- MERGE_WR:
  - mem_write = 1. mem_wdata = captured word with the addressed byte/halfword replaced by wdata[7:0] or wdata[15:0].
  - Next state RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle. resp_rdata and resp_err are driven from registers.
  - Next state IDLE. No new request is accepted in this cycle.
- Latency, counted from the acceptance edge:
  - Load and word store: resp_valid 2 cycles later.
  - Sub-word store: 3 cycles later.
  - Error: 1 cycle later.
- Throughput: one request every 3 cycles (4 for sub-word stores).
- Strobe rules:
  - mem_read and mem_write are never high in the same cycle.
  - Each is high for exactly one cycle per access.
  - When both strobes are low, mem_addr and mem_wdata hold 0.
- req_valid while req_ready = 0 is ignored. Request inputs are sampled only at the acceptance edge, so changes afterwards have no effect.

Test Plan:
- Reset mid-access:
  - Stimulus: assert reset during MERGE_WR.
  - Required: all outputs 0, req_ready = 1, memory word unchanged, no resp_valid.
- Word load:
  - Stimulus: memory[0x40] = 0x8899AABB; lw addr 0x40.
  - Required: mem_read with mem_addr 0x40 one cycle after accept; resp_valid 2 cycles after accept with resp_rdata 0x8899AABB, resp_err 0.
- Sub-word loads:
  - Stimulus: memory[0x40] = 0x8899AABB; lb signed at 0x43, then lbu at 0x43, then lh signed at 0x42.
  - Required: resp_rdata 0xFFFFFF88, then 0x00000088, then 0xFFFF8899.
- Byte store:
  - Stimulus: memory[0x40] = 0x11223344; sb addr 0x41, wdata 0xDEADBEEF.
  - Required: one mem_read cycle, then one mem_write cycle with mem_wdata 0x1122EF44; resp_valid 3 cycles after accept.
- Halfword store:
  - Stimulus: sh addr 0x42, wdata 0x0000CAFE onto 0x11223344.
  - Required: mem_wdata 0xCAFE3344.
- Errors:
  - Stimulus: lw addr 0x41; then sh addr 0x43; then req_size 11.
  - Required: resp_err 1 one cycle after accept, mem_read and mem_write never asserted.
- Back-to-back requests:
  - Stimulus: req_valid held high continuously.
  - Required: acceptance only in IDLE cycles; requests ignored during ACCESS, MERGE_WR and RESP.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide data memory
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

   state_t      state;
   logic        op_write;
   logic        op_unsigned;
   logic [1:0]  op_size;
   logic [1:0]  op_off;
   logic [15:0] op_wdata;
   logic        bad_req;
   logic        word_store;
   logic        op_sub_store;
   logic [4:0]  shamt;
   logic [15:0] lane;
   logic [31:0] lane_mask;
   logic [31:0] merge_data;
   logic [31:0] load_data;

   assign bad_req = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign word_store   = req_write && (req_size == 2'b10);
   assign op_sub_store = op_write && (op_size != 2'b10);

   // Little-endian lanes: byte offset n occupies bits [8n+7:8n]
   assign shamt      = {op_off, 3'b000};
   assign lane       = 16'(mem_rdata >> shamt);
   assign lane_mask  = ((op_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
   assign merge_data = (mem_rdata & ~lane_mask) | (({16'h0000, op_wdata} << shamt) & lane_mask);

   always_comb begin
      load_data = mem_rdata;
      if (op_size == 2'b00)
         load_data = {{24{lane[7] & ~op_unsigned}}, lane[7:0]};
      else if (op_size == 2'b01)
         load_data = {{16{lane[15] & ~op_unsigned}}, lane[15:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'h0;
         resp_err    <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 32'h0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         op_write    <= 1'b0;
         op_unsigned <= 1'b0;
         op_size     <= 2'b00;
         op_off      <= 2'b00;
         op_wdata    <= 16'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_write    <= req_write;
                  op_unsigned <= req_unsigned;
                  op_size     <= req_size;
                  op_off      <= req_addr[1:0];
                  op_wdata    <= req_wdata[15:0];
                  req_ready   <= 1'b0;
                  if (bad_req) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     state      <= RESP;
                  end else begin
                     // Strobes are registered, so the access is launched from here
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_read  <= !word_store;
                     mem_write <= word_store;
                     mem_wdata <= word_store ? req_wdata : 32'h0;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               mem_read <= 1'b0;
               if (op_sub_store) begin
                  mem_write <= 1'b1;
                  mem_wdata <= merge_data;
                  state     <= MERGE_WR;
               end else begin
                  mem_write  <= 1'b0;
                  mem_addr   <= '0;
                  mem_wdata  <= 32'h0;
                  resp_valid <= 1'b1;
                  resp_rdata <= op_write ? 32'h0 : load_data;
                  state      <= RESP;
               end
            end
            MERGE_WR: begin
               mem_write  <= 1'b0;
               mem_addr   <= '0;
               mem_wdata  <= 32'h0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_rdata <= 32'h0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table, corner-case and randomized checks of mem_access_unit
// Expected results come from a byte-array memory model and hand-derived constants.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_rdata;

   logic [31:0] mem [64];
   logic [7:0]  ref_bytes [256];
   int          n_vec = 0;
   int          n_bad = 0;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'hA5A5_A5A5;
   always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] v);
      mem[a[7:2]] = v;
      for (int i = 0; i < 4; i++) ref_bytes[int'(a[7:2]) * 4 + i] = v[8*i +: 8];
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b;
      b = int'(a[7:2]) * 4;
      return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
   endfunction

   // Reference: bytes are stored individually; loads sum them and sign-adjust arithmetically
   function automatic void model_req(input logic w, input logic [1:0] sz, input logic u,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic e, output int lat);
      int n;
      longint v;
      n  = 1 << sz;
      e  = (sz == 2'd3) || ((a % n) != 0);
      rd = 32'h0;
      lat = 1;
      if (e) return;
      if (w) begin
         for (int i = 0; i < n; i++) ref_bytes[int'(a[7:0]) + i] = wd[8*i +: 8];
         lat = (n == 4) ? 2 : 3;
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v += longint'(ref_bytes[int'(a[7:0]) + i]) << (8 * i);
         if (!u && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
         rd  = v[31:0];
         lat = 2;
      end
   endfunction

   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] o_rd, output logic o_err, output int o_lat);
      logic [31:0] e_rd, e_word, waddr;
      logic        e_err;
      int          e_lat, nrd, nwr;
      bit          bad_both, bad_idle, bad_addr, bad_wdata, bad_ready;
      model_req(w, sz, u, a, wd, e_rd, e_err, e_lat);
      waddr  = {a[31:2], 2'b00};
      e_word = ref_word(waddr);
      nrd = 0; nwr = 0; o_lat = 0; o_rd = 32'h0; o_err = 1'b0;
      bad_both = 0; bad_idle = 0; bad_addr = 0; bad_wdata = 0; bad_ready = 0;
      @(negedge clk);
      check("ready_before_req", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      for (int k = 1; k <= 5 && o_lat == 0; k++) begin
         if (k > 1) @(posedge clk);
         #1;
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (mem_read && mem_write) bad_both = 1;
         if (!mem_read && !mem_write && (mem_addr != 0 || mem_wdata != 0)) bad_idle = 1;
         if ((mem_read || mem_write) && mem_addr != waddr) bad_addr = 1;
         if (mem_write && mem_wdata != e_word) bad_wdata = 1;
         if (req_ready) bad_ready = 1;
         if (resp_valid) begin
            o_lat = k; o_rd = resp_rdata; o_err = resp_err;
         end
         if (k == 1) begin
            // Post-acceptance changes on the request bus must be ignored
            req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
            req_addr = $urandom_range(0, 255); req_wdata = $urandom;
         end
      end
      req_valid = 1'b0;
      check("latency", o_lat, e_lat);
      check("rdata", o_rd, e_rd);
      check("err", {31'h0, o_err}, {31'h0, e_err});
      check("read_strobes", nrd, (!e_err && !(w && sz == 2'd2)) ? 1 : 0);
      check("write_strobes", nwr, (!e_err && w) ? 1 : 0);
      check("dual_strobe", {31'h0, bad_both}, 32'h0);
      check("idle_bus_zero", {31'h0, bad_idle}, 32'h0);
      check("mem_addr", {31'h0, bad_addr}, 32'h0);
      check("mem_wdata", {31'h0, bad_wdata}, 32'h0);
      check("busy_ready", {31'h0, bad_ready}, 32'h0);
      check("mem_word", mem[waddr[7:2]], ref_word(waddr));
      @(posedge clk); #1;
      check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
      check("ready_after", {31'h0, req_ready}, 32'h1);
   endtask

   typedef struct {
      bit          pk;
      logic [31:0] pv;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] word;
   } vec_t;

   vec_t        tbl [15];
   logic [31:0] rd, a;
   logic        er;
   int          lat;
   logic [1:0]  sz;
   logic [31:0] exp_q [$];
   bit          saw_resp;

   initial begin
      tbl[0]  = '{1, 32'h8899AABB, 0, 2'd2, 0, 32'h40, 32'h0,        32'h8899AABB, 0, 2, 32'h8899AABB};
      tbl[1]  = '{0, 32'h0,        0, 2'd0, 0, 32'h43, 32'h0,        32'hFFFFFF88, 0, 2, 32'h8899AABB};
      tbl[2]  = '{0, 32'h0,        0, 2'd0, 1, 32'h43, 32'h0,        32'h00000088, 0, 2, 32'h8899AABB};
      tbl[3]  = '{0, 32'h0,        0, 2'd1, 0, 32'h42, 32'h0,        32'hFFFF8899, 0, 2, 32'h8899AABB};
      tbl[4]  = '{1, 32'h11223344, 1, 2'd0, 0, 32'h41, 32'hDEADBEEF, 32'h0,        0, 3, 32'h1122EF44};
      tbl[5]  = '{1, 32'h11223344, 1, 2'd1, 0, 32'h42, 32'h0000CAFE, 32'h0,        0, 3, 32'hCAFE3344};
      tbl[6]  = '{0, 32'h0,        0, 2'd2, 0, 32'h41, 32'h0,        32'h0,        1, 1, 32'hCAFE3344};
      tbl[7]  = '{0, 32'h0,        1, 2'd1, 0, 32'h43, 32'h12345678, 32'h0,        1, 1, 32'hCAFE3344};
      tbl[8]  = '{0, 32'h0,        0, 2'd3, 0, 32'h40, 32'h0,        32'h0,        1, 1, 32'hCAFE3344};
      tbl[9]  = '{0, 32'h0,        0, 2'd1, 1, 32'h42, 32'h0,        32'h0000CAFE, 0, 2, 32'hCAFE3344};
      tbl[10] = '{0, 32'h0,        0, 2'd0, 0, 32'h40, 32'h0,        32'h00000044, 0, 2, 32'hCAFE3344};
      tbl[11] = '{0, 32'h0,        0, 2'd1, 0, 32'h40, 32'h0,        32'h00003344, 0, 2, 32'hCAFE3344};
      tbl[12] = '{0, 32'h0,        0, 2'd0, 0, 32'h42, 32'h0,        32'hFFFFFFFE, 0, 2, 32'hCAFE3344};
      tbl[13] = '{1, 32'h0,        1, 2'd2, 0, 32'h44, 32'h12345678, 32'h0,        0, 2, 32'h12345678};
      tbl[14] = '{0, 32'h0,        1, 2'd2, 0, 32'h46, 32'hFFFFFFFF, 32'h0,        1, 1, 32'h12345678};

      for (int i = 0; i < 64; i++) poke(i * 4, $urandom);

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_outs", {26'h0, resp_valid, resp_err, mem_read, mem_write, |mem_addr, |mem_wdata}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].pk) poke(tbl[i].a, tbl[i].pv);
         do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, rd, er, lat);
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         check($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].er});
         check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d_word", i), mem[tbl[i].a[7:2]], tbl[i].word);
      end

      // Reset while the merged word is on the bus: no write, no response
      poke(32'h40, 32'h11223344);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h41; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_merge_write", {31'h0, mem_write}, 32'h1);
      reset = 1'b1;
      #1;
      check("midrst_ready", {31'h0, req_ready}, 32'h1);
      check("midrst_outs", {26'h0, resp_valid, resp_err, mem_read, mem_write, |mem_addr, |mem_wdata}, 32'h0);
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      saw_resp = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (resp_valid || mem_write || mem_read) saw_resp = 1;
      end
      check("midrst_no_activity", {31'h0, saw_resp}, 32'h0);
      check("midrst_mem_word", mem[16], 32'h11223344);
      check("midrst_ready_idle", {31'h0, req_ready}, 32'h1);

      // Back-to-back word loads with req_valid held high
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         a = 32'h80 + 4 * $urandom_range(0, 31);
         req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = a;
         check($sformatf("b2b%0d_ready", i), {31'h0, req_ready}, (i % 3 == 0) ? 32'h1 : 32'h0);
         if (i % 3 == 0) begin
            model_req(1'b0, 2'd2, 1'b0, a, 32'h0, rd, er, lat);
            exp_q.push_back(rd);
         end
         @(posedge clk); #1;
         check($sformatf("b2b%0d_resp", i), {31'h0, resp_valid}, (i % 3 == 1) ? 32'h1 : 32'h0);
         if (resp_valid && exp_q.size() > 0) check("b2b_rdata", resp_rdata, exp_q.pop_front());
      end
      req_valid = 1'b0;
      check("b2b_drain", exp_q.size(), 0);

      for (int t = 0; t < 60; t++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er, lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
